// File: rtl/uart_tx_ctrl.sv
// Memory-mapped 8N1 UART transmitter: CPU bytes go into a TX FIFO and are serialized on tx_o.
// STATUS exposes FIFO level and a sticky overflow flag so firmware can poll before writing.
module uart_tx_ctrl #(
    parameter int unsigned CLK_FREQ_HZ      = 50_000_000,
    parameter int unsigned BAUD             = 115_200,
    parameter int unsigned FIFO_DEPTH       = 16,
    parameter int unsigned IO_MEM_MAP_BIT   = 22,
    parameter int unsigned UART_MEM_MAP_BIT = 4,
    parameter bit          SIM_ECHO         = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr_i,
    input  logic        mem_rstrb_i,
    output logic [31:0] mem_rdata_o,
    input  logic [3:0]  mem_wmask_i,
    input  logic [31:0] mem_wdata_i,
    output logic        tx_o,
    output logic        tx_idle_o
);

    localparam int unsigned DIV = CLK_FREQ_HZ / BAUD;
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned BW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [31:0]     rdata_q, rdata_d;

    logic sel, is_status, push, push_ok, push_drop, ovf_clr;
    logic full, empty, pop, bit_end;
    logic [7:0]  count8;
    logic [31:0] status;
    logic        unused_bits;

    assign sel       = mem_addr_i[IO_MEM_MAP_BIT] & mem_addr_i[UART_MEM_MAP_BIT];
    assign is_status = mem_addr_i[2];
    assign push      = sel & ~is_status & mem_wmask_i[0];
    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    // Full is judged on the registered count, so a same-cycle pop cannot rescue a push.
    assign push_ok   = push & ~full;
    assign push_drop = push & full;
    assign ovf_clr   = sel & is_status & mem_wmask_i[0] & mem_wdata_i[3];
    assign bit_end   = (baud_q == BW'(DIV - 1));

    assign count8 = 8'(count_q);
    assign status = {16'h0000, count8, 4'h0, ovf_q, (state_q != StIdle), empty, full};

    assign unused_bits = ^{mem_addr_i, mem_wdata_i[31:8], mem_wmask_i[3:1]};

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        if (state_q != StIdle) begin
            baud_d = bit_end ? '0 : baud_q + BW'(1);
        end
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_mem[rptr_q];
                    baud_d  = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_mem[rptr_q];
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line level is registered from the next state to keep tx_o glitch-free.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q;
        if (push_drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        rdata_d = rdata_q;
        if (sel && mem_rstrb_i) begin
            rdata_d = is_status ? status : 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            rdata_q <= rdata_d;
            if (push_ok) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wptr_q] <= mem_wdata_i[7:0];
        end
    end

    if (SIM_ECHO) begin : g_echo
        always_ff @(posedge clk) begin
            if (!rst && push_ok) begin
                $display("[%0t ps][UART]: %c", $time, mem_wdata_i[7:0]);
            end
        end
    end

    assign mem_rdata_o = rdata_q;
    assign tx_o        = tx_q;
    assign tx_idle_o   = empty && (state_q == StIdle);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: a frame-timing model predicts tx_o, tx_idle_o and read data every cycle,
// and directed scenarios add literal checks that pin the model.
module tb_uart_tx_ctrl;

    localparam int DIV   = 10;
    localparam int DEPTH = 4;
    localparam logic [31:0] A_DATA       = 32'h0040_0010;
    localparam logic [31:0] A_STAT       = 32'h0040_0014;
    localparam logic [31:0] A_NOSEL_DATA = 32'h0040_0000;
    localparam logic [31:0] A_NOSEL_STAT = 32'h0040_0004;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_addr = '0;
    logic        mem_rstrb = 1'b0;
    logic [31:0] mem_rdata;
    logic [3:0]  mem_wmask = '0;
    logic [31:0] mem_wdata = '0;
    logic        tx_o;
    logic        tx_idle_o;

    uart_tx_ctrl #(
        .CLK_FREQ_HZ      (1_000_000),
        .BAUD             (100_000),
        .FIFO_DEPTH       (DEPTH),
        .IO_MEM_MAP_BIT   (22),
        .UART_MEM_MAP_BIT (4),
        .SIM_ECHO         (1'b0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_addr_i  (mem_addr),
        .mem_rstrb_i (mem_rstrb),
        .mem_rdata_o (mem_rdata),
        .mem_wmask_i (mem_wmask),
        .mem_wdata_i (mem_wdata),
        .tx_o        (tx_o),
        .tx_idle_o   (tx_idle_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Model: queued bytes plus the edge index at which the current frame's start bit began.
    logic [7:0]  q[$];
    bit          m_busy = 1'b0;
    bit          m_ovf  = 1'b0;
    bit          model_on = 1'b0;
    int          fs = 0;
    logic [7:0]  fb = '0;
    logic [31:0] m_rdata = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic exp_tx();
        int pos;
        if (!m_busy) return 1'b1;
        pos = (cyc - fs) / DIV;
        if (pos == 0) return 1'b0;
        if (pos <= 8) return fb[pos-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_status();
        logic [7:0] n;
        n = 8'(q.size());
        return {16'h0, n, 4'h0, m_ovf, m_busy, (q.size() == 0), (q.size() == DEPTH)};
    endfunction

    always @(posedge clk) begin : model
        bit pop, accept, pre_full, pre_empty, sel;
        logic [31:0] pre_stat;
        cyc++;
        if (rst) begin
            q.delete();
            m_busy   = 1'b0;
            m_ovf    = 1'b0;
            m_rdata  = '0;
            model_on = 1'b1;
        end else if (model_on) begin
            pre_full  = (q.size() == DEPTH);
            pre_empty = (q.size() == 0);
            pre_stat  = m_status();
            sel       = mem_addr[22] && mem_addr[4];
            pop       = 1'b0;
            accept    = 1'b0;
            if (!m_busy) begin
                pop = !pre_empty;
            end else if (cyc - fs == 10 * DIV) begin
                if (!pre_empty) pop = 1'b1;
                else m_busy = 1'b0;
            end
            if (sel && mem_rstrb) m_rdata = mem_addr[2] ? pre_stat : 32'h0;
            if (sel && mem_wmask[0] && !mem_addr[2]) begin
                if (pre_full) m_ovf = 1'b1;
                else accept = 1'b1;
            end
            if (sel && mem_wmask[0] && mem_addr[2] && mem_wdata[3]) m_ovf = 1'b0;
            if (pop) begin
                fb     = q.pop_front();
                fs     = cyc;
                m_busy = 1'b1;
            end
            if (accept) q.push_back(mem_wdata[7:0]);
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("tx_o", {31'h0, tx_o}, {31'h0, exp_tx()});
            chk("tx_idle_o", {31'h0, tx_idle_o}, {31'h0, (!m_busy && q.size() == 0)});
            chk("mem_rdata_o", mem_rdata, m_rdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        mem_addr  = '0;
        mem_rstrb = 1'b0;
        mem_wmask = '0;
        mem_wdata = '0;
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d);
        mem_addr  = a;
        mem_wdata = d;
        mem_wmask = 4'b0001;
        tick();
        bus_idle();
    endtask

    task automatic read(input logic [31:0] a);
        mem_addr  = a;
        mem_rstrb = 1'b1;
        tick();
        bus_idle();
    endtask

    task automatic at_cycle(input int c);
        while (cyc < c) tick();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int p;
        bus_idle();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset tx", {31'h0, tx_o}, 32'h1);
        chk("reset idle", {31'h0, tx_idle_o}, 32'h1);
        chk("reset rdata", mem_rdata, 32'h0);

        // 1: single 0x55 frame
        write(A_DATA, 32'h55);
        p = cyc;
        at_cycle(p + 1);   chk("t1 start", {31'h0, tx_o}, 32'h0);
        at_cycle(p + 10);  chk("t1 start end", {31'h0, tx_o}, 32'h0);
        at_cycle(p + 11);  chk("t1 bit0", {31'h0, tx_o}, 32'h1);
        at_cycle(p + 21);  chk("t1 bit1", {31'h0, tx_o}, 32'h0);
        at_cycle(p + 81);  chk("t1 bit7", {31'h0, tx_o}, 32'h0);
        at_cycle(p + 91);  chk("t1 stop", {31'h0, tx_o}, 32'h1);
        at_cycle(p + 100); chk("t1 busy at 100", {31'h0, tx_idle_o}, 32'h0);
        at_cycle(p + 101); chk("t1 idle at 101", {31'h0, tx_idle_o}, 32'h1);

        // 2: back-to-back frames
        write(A_DATA, 32'h41);
        p = cyc;
        write(A_DATA, 32'h42);
        at_cycle(p + 11);  chk("t2 A bit0", {31'h0, tx_o}, 32'h1);
        at_cycle(p + 100); chk("t2 A stop", {31'h0, tx_o}, 32'h1);
        at_cycle(p + 101); chk("t2 B start", {31'h0, tx_o}, 32'h0);
        at_cycle(p + 111); chk("t2 B bit0", {31'h0, tx_o}, 32'h0);
        at_cycle(p + 121); chk("t2 B bit1", {31'h0, tx_o}, 32'h1);
        at_cycle(p + 200); chk("t2 busy", {31'h0, tx_idle_o}, 32'h0);
        at_cycle(p + 201); chk("t2 idle", {31'h0, tx_idle_o}, 32'h1);

        // 3: overflow
        for (int i = 0; i < 6; i++) write(A_DATA, 32'h61 + i);
        read(A_STAT);
        @(negedge clk);
        chk("t3 status full+ovf", mem_rdata, 32'h0000_040D);
        write(A_STAT, 32'h8);
        read(A_STAT);
        @(negedge clk);
        chk("t3 status ovf cleared", mem_rdata, 32'h0000_0405);
        for (int i = 0; i < 1000 && !tx_idle_o; i++) tick();
        chk("t3 drain", {31'h0, tx_idle_o}, 32'h1);

        // 4: status read on empty idle block
        read(A_STAT);
        @(negedge clk);
        chk("t4 status", mem_rdata, 32'h0000_0002);
        repeat (5) tick();
        @(negedge clk);
        chk("t4 hold", mem_rdata, 32'h0000_0002);

        // 5: reset mid-frame
        write(A_DATA, 32'hA5);
        p = cyc;
        write(A_DATA, 32'h5A);
        at_cycle(p + 34);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t5 tx after rst", {31'h0, tx_o}, 32'h1);
        chk("t5 idle after rst", {31'h0, tx_idle_o}, 32'h1);
        read(A_STAT);
        @(negedge clk);
        chk("t5 status", mem_rdata, 32'h0000_0002);
        repeat (150) tick();
        @(negedge clk);
        chk("t5 no start", {31'h0, tx_o}, 32'h1);

        // 6: unselected accesses
        write(A_NOSEL_DATA, 32'h33);
        read(A_NOSEL_STAT);
        repeat (3) tick();
        @(negedge clk);
        chk("t6 rdata held", mem_rdata, 32'h0000_0002);
        chk("t6 tx", {31'h0, tx_o}, 32'h1);
        read(A_STAT);
        @(negedge clk);
        chk("t6 fifo empty", mem_rdata, 32'h0000_0002);
        read(A_DATA);
        @(negedge clk);
        chk("t6 data read zero", mem_rdata, 32'h0);

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
